axi_lite_master: RTL and testbench
==================================

// Module: axi_lite_master
// PURPOSE
//  AXI4-Lite initiator: turns single-beat register commands from a local valid/ready port into
//  AW/W/B or AR/R transactions toward axi_lite_slave (4 x 32-bit regs, no BRESP/RRESP).
//  One outstanding transaction; result returned on a valid/ready response port.
//  Sits between the test/CPU-side sequencer and the slave in the verification top.
// PARAMETERS
//  ADDR_WIDTH      4    AXI address width (byte address; slave decodes [3:2])
//  DATA_WIDTH      32   AXI data width; WSTRB width = DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  watchdog limit per wait phase (used only with AXIL_MST_TIMEOUT_EN)
// PORTS
//  ACLK         in   1    clock, all logic on rising edge
//  ARESETn      in   1    asynchronous, active-low reset
//  cmd_valid    in   1    command request
//  cmd_ready    out  1    command accepted when cmd_valid && cmd_ready
//  cmd_write    in   1    1 = write, 0 = read
//  cmd_addr     in   AW   byte address
//  cmd_wdata    in   DW   write data (ignored for reads)
//  cmd_wstrb    in   DW/8 byte strobes (ignored for reads)
//  rsp_valid    out  1    response available
//  rsp_ready    in   1    response consumed when rsp_valid && rsp_ready
//  rsp_write    out  1    echo of cmd_write for this response
//  rsp_rdata    out  DW   read data (0 for writes)
//  rsp_timeout  out  1    transaction aborted by watchdog (constant 0 without macro)
//  AWADDR/AWVALID out AW/1, AWREADY in 1    write address channel
//  WDATA/WSTRB/WVALID out DW/DW/8/1, WREADY in 1   write data channel
//  BVALID in 1, BREADY out 1                 write response channel
//  ARADDR/ARVALID out AW/1, ARREADY in 1    read address channel
//  RDATA in DW, RVALID in 1, RREADY out 1   read data channel
// BEHAVIOUR
//  Reset (async, any state): all VALID/READY outputs 0, cmd_ready 0, rsp_* 0, state IDLE.
//  States: IDLE -> WR_AW_W -> WR_B -> RSP -> IDLE ; IDLE -> RD_AR -> RD_R -> RSP -> IDLE.
//  IDLE: cmd_ready=1 (from first edge after reset release). On accept, latch cmd fields;
//   cmd_ready drops next cycle; only one command in flight, cmd_ready=0 outside IDLE.
//  WR_AW_W: AWVALID and WVALID rise together on cycle after accept (slave requires both
//   high in the same cycle). Each held with stable AWADDR/WDATA/WSTRB until its own
//   handshake, then dropped independently; leave when both done. BREADY=1 in WR_B.
//  WR_B: on BVALID&&BREADY -> BREADY=0, rsp_write=1, rsp_rdata=0, go RSP.
//  RD_AR: ARVALID=1, ARADDR stable until ARVALID&&ARREADY; then ARVALID=0, RREADY=1.
//  RD_R: on RVALID&&RREADY capture RDATA into rsp_rdata, RREADY=0, go RSP.
//  RSP: rsp_valid=1, payload stable until rsp_ready; back to IDLE next cycle (cmd_ready=1).
//  Latency: rsp_valid asserts exactly 1 cycle after the B or R handshake edge.
//  VALIDs never deassert before handshake; no combinational path cmd_* -> AXI outputs.
//  BVALID/RVALID arriving outside WR_B/RD_R are ignored (READY low).
//  rsp_ready high while rsp_valid low has no effect; cmd_valid during RSP is not accepted.
// CONFIGURATION
//  AXIL_MST_TIMEOUT_EN defined: cycle counter clears on every state change; if it reaches
//   TIMEOUT_CYCLES in WR_AW_W/WR_B/RD_AR/RD_R, all AXI VALID/READY drop next cycle, go RSP
//   with rsp_timeout=1, rsp_rdata=0. Undefined: no counter, waits forever, rsp_timeout tied 0.
// STRUCTURE
//  axil_pkg: axil_mst_state_t enum, default width constants, strobe-width function.
//  Sub-module axil_mst_watchdog (counter + expiry flag), instantiated only under macro.
// TESTING
//  Write 0x4, data 0xDEADBEEF, strb 0xF -> AW/W high same cycle, rsp_valid rsp_write=1, reg1=0xDEADBEEF.
//  Then read 0x4 -> ARVALID until ARREADY, rsp_rdata=0xDEADBEEF, rsp_write=0.
//  Write 0x8 data 0x11223344 strb 0x5 over 0x0 -> readback 0x00220044.
//  AWREADY delayed 3 cycles vs WREADY -> WVALID drops after its handshake, AWVALID held; one B.
//  rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready 0 throughout.
//  ARESETn low mid RD_R -> all outputs 0 immediately; with macro, stalled BVALID -> rsp_timeout=1 at 256 cycles.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and defaults for the AXI4-Lite master and its watchdog.
package axil_pkg;

  localparam int AXIL_ADDR_W  = 4;
  localparam int AXIL_DATA_W  = 32;
  localparam int AXIL_TIMEOUT = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } axil_mst_state_t;

  function automatic int strb_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axil_mst_watchdog.sv
// Per-state wait watchdog: a down-counter reloaded whenever the master changes
// state; expired is high during the TIMEOUT_CYCLES-th consecutive cycle spent
// in a single wait state.
module axil_mst_watchdog
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  axil_mst_state_t state,
  output logic            expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  axil_mst_state_t state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   remaining;
  logic            waiting;

  // First cycle in a new state starts from a full count.
  assign remaining = (state != state_q) ? LOAD : cnt_q;
  assign waiting   = state inside {ST_WR_AW_W, ST_WR_B, ST_RD_AR, ST_RD_R};
  assign expired   = waiting && (remaining == '0);

  // Track the previous state and count down, holding at terminal count.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state;
      cnt_q   <= (remaining == '0) ? '0 : remaining - 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one single-beat command at a time from the cmd port,
// executed as AW/W/B or AR/R, with the result returned on the rsp port.
// Optional watchdog abort on stalled wait phases: define AXIL_MST_TIMEOUT_EN.
module axi_lite_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXIL_ADDR_W,
  parameter int DATA_WIDTH     = AXIL_DATA_W,
  parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [ADDR_WIDTH-1:0]             cmd_addr,
  input  logic [DATA_WIDTH-1:0]             cmd_wdata,
  input  logic [strb_width(DATA_WIDTH)-1:0] cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_timeout,
  output logic [ADDR_WIDTH-1:0]             AWADDR,
  output logic                              AWVALID,
  input  logic                              AWREADY,
  output logic [DATA_WIDTH-1:0]             WDATA,
  output logic [strb_width(DATA_WIDTH)-1:0] WSTRB,
  output logic                              WVALID,
  input  logic                              WREADY,
  input  logic                              BVALID,
  output logic                              BREADY,
  output logic [ADDR_WIDTH-1:0]             ARADDR,
  output logic                              ARVALID,
  input  logic                              ARREADY,
  input  logic [DATA_WIDTH-1:0]             RDATA,
  input  logic                              RVALID,
  output logic                              RREADY
);

  axil_mst_state_t state;
  logic            wr_q;
  logic            aw_hs;
  logic            w_hs;

`ifdef AXIL_MST_TIMEOUT_EN
  logic wd_expired;

  axil_mst_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .state   (state),
    .expired (wd_expired)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;

  // Transaction sequencer; every output is registered so nothing on cmd_*
  // reaches the AXI pins combinationally.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      wr_q      <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end
`ifdef AXIL_MST_TIMEOUT_EN
    else if (wd_expired) begin
      AWVALID     <= 1'b0;
      WVALID      <= 1'b0;
      BREADY      <= 1'b0;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_write   <= wr_q;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b1;
      state       <= ST_RSP;
    end
`endif
    else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            wr_q      <= cmd_write;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              WSTRB   <= cmd_wstrb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= ST_WR_AW_W;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state   <= ST_RD_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_WR_AW_W: begin
          if (aw_hs) AWVALID <= 1'b0;
          if (w_hs)  WVALID  <= 1'b0;
          if ((!AWVALID || aw_hs) && (!WVALID || w_hs)) begin
            BREADY <= 1'b1;
            state  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (BVALID && BREADY) begin
            BREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RSP;
          end
        end
        ST_RD_AR: begin
          if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (RVALID && RREADY) begin
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= RDATA;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
`ifdef AXIL_MST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural 4-register slave with adjustable
// ready/valid delays, scoreboard of expected responses, independent monitor.
module tb_axi_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;

  axi_lite_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] regs [4];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  bit b_stall = 0;
  int b_count = 0;

  initial begin : slave
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit aw_have, w_have, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic [3:0] aw_a, ar_a, w_s;
    logic [31:0] w_d, r_word;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RDATA = '0;
    aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_a = '0; ar_a = '0; w_s = '0; w_d = '0; r_word = '0;
    forever begin
      @(negedge ACLK);
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      hs_b  = BVALID && BREADY;
      hs_ar = ARVALID && ARREADY;
      hs_r  = RVALID && RREADY;
      if (hs_aw) aw_a = AWADDR;
      if (hs_w) begin w_d = WDATA; w_s = WSTRB; end
      if (hs_ar) ar_a = ARADDR;
      if (AWVALID && !AWREADY) aw_cnt++;
      if (WVALID && !WREADY) w_cnt++;
      if (ARVALID && !ARREADY) ar_cnt++;
      if (r_pend) r_cnt++;
      @(posedge ACLK); #1;
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (hs_aw) begin AWREADY = 0; aw_have = 1; aw_cnt = 0; end
        if (hs_w)  begin WREADY = 0; w_have = 1; w_cnt = 0; end
        if (hs_b)  begin BVALID = 0; b_count++; end
        if (hs_ar) begin ARREADY = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0; r_word = regs[ar_a[3:2]]; end
        if (hs_r)  RVALID = 0;
        if (aw_have && w_have) begin
          for (int b = 0; b < 4; b++)
            if (w_s[b]) regs[aw_a[3:2]][8*b +: 8] = w_d[8*b +: 8];
          aw_have = 0; w_have = 0; b_pend = 1;
        end
        if (AWVALID && !AWREADY && !aw_have && aw_cnt >= aw_dly) AWREADY = 1;
        if (WVALID && !WREADY && !w_have && w_cnt >= w_dly) WREADY = 1;
        if (ARVALID && !ARREADY && !r_pend && !RVALID && ar_cnt >= ar_dly) ARREADY = 1;
        if (b_pend && !b_stall) begin BVALID = 1; b_pend = 0; end
        if (r_pend && r_cnt >= r_dly) begin RVALID = 1; RDATA = r_word; r_pend = 0; end
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    bit          write;
    logic [31:0] rdata;
    bit          timeout;
  } exp_t;
  exp_t sb[$];

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETn && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_write", rsp_write, e.write);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_timeout", rsp_timeout, e.timeout);
        end
      end
    end
  end

  // VALID must stay high with a stable payload until its handshake.
  initial begin : protocol
    bit aw_h = 0, w_h = 0, ar_h = 0;
    logic [3:0] aw_p = '0, ar_p = '0;
    logic [35:0] w_p = '0;
    forever begin
      @(negedge ACLK);
      if (ARESETn) begin
        if (aw_h) check("awvalid_held", {AWVALID, AWADDR}, {1'b1, aw_p});
        if (w_h)  check("wvalid_held", {WVALID, WSTRB, WDATA}, {1'b1, w_p});
        if (ar_h) check("arvalid_held", {ARVALID, ARADDR}, {1'b1, ar_p});
      end
      aw_h = ARESETn && AWVALID && !AWREADY; aw_p = AWADDR;
      w_h  = ARESETn && WVALID && !WREADY;   w_p  = {WSTRB, WDATA};
      ar_h = ARESETn && ARVALID && !ARREADY; ar_p = ARADDR;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit wr, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input bit exp_to);
    bit hs;
    sb.push_back('{write: wr, rdata: exp_rd, timeout: exp_to});
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    hs = 0;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge ACLK);
      hs = cmd_ready;
      @(posedge ACLK); #1;
    end
    cmd_valid = 0;
    if (!hs) check("cmd_accept_bound", 0, 1);
  endtask

  task automatic wait_rsp(input int limit);
    for (int n = 0; n < limit && sb.size() != 0; n++) begin
      @(posedge ACLK); #1;
    end
    if (sb.size() != 0) begin
      check("rsp_wait_bound", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin : watchdog_tb
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    int bc, hold;
    logic [31:0] held;
    repeat (3) @(posedge ACLK);
    #1;
    check("reset_ctrl", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_timeout}, 9'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    ARESETn = 1;
    @(posedge ACLK); #1;
    check("cmd_ready_after_reset", cmd_ready, 1);

    // write 0x4 full word; AW and W must rise together
    bc = b_count;
    issue(1, 4'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    check("aw_w_same_cycle", {AWVALID, WVALID}, 2'b11);
    check("cmd_ready_busy", cmd_ready, 0);
    wait_rsp(100);
    check("reg1_written", regs[1], 32'hDEADBEEF);
    check("one_b_first", b_count - bc, 1);

    // read back with ARREADY held off
    ar_dly = 2;
    issue(0, 4'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    check("arvalid_up", ARVALID, 1);
    wait_rsp(100);
    ar_dly = 0;

    // byte strobes over a zero register
    issue(1, 4'h8, 32'h11223344, 4'h5, 32'h0, 0);
    wait_rsp(100);
    issue(0, 4'h8, 32'h0, 4'h0, 32'h00220044, 0);
    wait_rsp(100);

    // AWREADY three cycles behind WREADY
    aw_dly = 3;
    bc = b_count;
    issue(1, 4'hC, 32'hA5A55A5A, 4'hF, 32'h0, 0);
    check("aw_w_rise_delayed", {AWVALID, WVALID}, 2'b11);
    @(posedge ACLK); #1;
    check("w_dropped_aw_held", {AWVALID, WVALID}, 2'b10);
    wait_rsp(100);
    aw_dly = 0;
    check("one_b_delayed_aw", b_count - bc, 1);
    check("reg3_written", regs[3], 32'hA5A55A5A);

    // response back-pressure; a new command meanwhile must not be taken
    rsp_ready = 0;
    issue(0, 4'h8, 32'h0, 4'h0, 32'h00220044, 0);
    hold = 0;
    while (!rsp_valid && hold < 50) begin @(posedge ACLK); #1; hold++; end
    check("rsp_valid_seen", rsp_valid, 1);
    held = rsp_rdata;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check("rsp_hold_valid", rsp_valid, 1);
      check("rsp_hold_rdata", rsp_rdata, held);
      check("rsp_hold_cmd_ready", cmd_ready, 0);
      @(posedge ACLK); #1;
    end
    cmd_valid = 0;
    check("no_write_during_rsp", AWVALID, 0);
    rsp_ready = 1;
    wait_rsp(100);
    check("held_rdata_value", held, 32'h00220044);

    // asynchronous reset while waiting for R
    r_dly = 1000;
    issue(0, 4'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    hold = 0;
    while (!RREADY && hold < 50) begin @(posedge ACLK); #1; hold++; end
    check("rready_before_reset", RREADY, 1);
    #2;
    ARESETn = 0;
    #1;
    check("async_reset_ctrl", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_timeout}, 9'h0);
    check("async_reset_rdata", rsp_rdata, 32'h0);
    sb.delete();
    repeat (3) @(posedge ACLK);
    #1;
    r_dly = 0;
    ARESETn = 1;
    issue(0, 4'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    wait_rsp(100);

`ifdef AXIL_MST_TIMEOUT_EN
    // stalled B channel: BREADY for exactly 256 cycles, then timeout response
    b_stall = 1;
    issue(1, 4'h0, 32'h12345678, 4'hF, 32'h0, 1);
    bc = 0;
    hold = 0;
    while (!rsp_valid && hold < 600) begin
      @(negedge ACLK);
      if (BREADY) bc++;
      hold++;
    end
    check("bready_cycles_to_timeout", bc, 256);
    check("timeout_rsp_valid", rsp_valid, 1);
    wait_rsp(100);
`endif

    repeat (2) @(posedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
